// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the program loader.
// Build macro LOADER_TIMEOUT_EN (used by the loader) enables the inter-byte timeout.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CSUM,
        RUN,
        ERROR
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         INSTR_W   = 16;

endpackage

// File: rtl/loader_timeout.sv
// loader_timeout: inter-byte stall counter for the program loader.
// Only compiled in when LOADER_TIMEOUT_EN is defined; the default build has
// no timeout and this module does not exist.
`ifdef LOADER_TIMEOUT_EN
module loader_timeout #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    // count idle cycles while enabled; any accepted byte or leaving the frame restarts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr || !en) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // the LIMIT-th consecutive idle cycle is the one that fires
    assign expired = en && !clr && (cnt_q == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/program_loader.sv
// program_loader: receives a framed byte-stream program image, writes the
// big-endian 16-bit words into instruction memory from address 0 with the core
// held in reset, then releases the core once the XOR checksum matches.
// Frame: A5, LEN_HI, LEN_LO, N x (INSTR_HI, INSTR_LO), CSUM.
// Build macro LOADER_TIMEOUT_EN: abort a stalled frame into ERROR after
// TIMEOUT_CYCLES cycles without an accepted byte.
//
// state   | meaning
// IDLE    | waiting for sync, other bytes dropped
// LEN_HI  | expecting length high byte
// LEN_LO  | expecting length low byte, range check
// DATA_HI | expecting instruction high byte
// DATA_LO | expecting instruction low byte, triggers memory write
// CSUM    | expecting checksum byte
// RUN     | core released; sync restarts a load
// ERROR   | load failed, core held; sync restarts a load
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               core_reset,
    input  logic               core_halt,
    output logic               load_done,
    output logic               load_error,
    output logic               halted
);
    localparam logic [16:0]     MAX_WORDS = 17'(1) << ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic                accept, is_sync, we_d, in_frame, timeout_hit;
    logic [15:0]         frame_len;
    logic [ADDR_W:0]     cnt_q, cnt_inc, len_q;
    logic [7:0]          len_hi_q, hi_q, csum_q;
    logic                rdy_q, we_q, err_q, halt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [INSTR_W-1:0]  wdata_q;

    assign accept    = rx_valid && rdy_q;
    assign is_sync   = (rx_data == SYNC_BYTE);
    assign frame_len = {len_hi_q, rx_data};
    assign cnt_inc   = cnt_q + CNT_ONE;
    assign in_frame  = state_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM};

`ifdef LOADER_TIMEOUT_EN
    loader_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (accept),
        .en      (in_frame),
        .expired (timeout_hit)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^{TIMEOUT_CYCLES, in_frame};
    assign timeout_hit    = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state decode and the write strobe request for the next cycle
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        case (state_q)
            IDLE, ERROR, RUN: begin
                if (accept && is_sync) state_d = LEN_HI;
            end
            LEN_HI: begin
                if (accept) state_d = LEN_LO;
            end
            LEN_LO: begin
                if (accept) begin
                    if ({1'b0, frame_len} > MAX_WORDS) state_d = ERROR;
                    else if (frame_len == 16'd0)       state_d = CSUM;
                    else                               state_d = DATA_HI;
                end
            end
            DATA_HI: begin
                if (accept) state_d = DATA_LO;
            end
            DATA_LO: begin
                if (accept) begin
                    we_d    = 1'b1;
                    state_d = (cnt_inc == len_q) ? CSUM : DATA_HI;
                end
            end
            CSUM: begin
                if (accept) state_d = (rx_data == csum_q) ? RUN : ERROR;
            end
            default: state_d = IDLE;
        endcase
        if (timeout_hit) state_d = ERROR;
    end

    // datapath: checksum, word assembly, memory write port and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            len_hi_q <= '0;
            hi_q     <= '0;
            csum_q   <= '0;
            err_q    <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            // ready drops exactly during the write-back cycle
            rdy_q <= !we_d;
            we_q  <= we_d;
            if (state_q == RUN && core_halt) halt_q <= 1'b1;
            if (accept) begin
                case (state_q)
                    IDLE, ERROR, RUN: begin
                        if (is_sync) begin
                            csum_q <= '0;
                            cnt_q  <= '0;
                            err_q  <= 1'b0;
                            halt_q <= 1'b0;
                        end
                    end
                    LEN_HI: begin
                        len_hi_q <= rx_data;
                        csum_q   <= csum_q ^ rx_data;
                    end
                    LEN_LO: begin
                        len_q  <= frame_len[ADDR_W:0];
                        csum_q <= csum_q ^ rx_data;
                    end
                    DATA_HI: begin
                        hi_q   <= rx_data;
                        csum_q <= csum_q ^ rx_data;
                    end
                    DATA_LO: begin
                        addr_q  <= cnt_q[ADDR_W-1:0];
                        wdata_q <= {hi_q, rx_data};
                        cnt_q   <= cnt_inc;
                        csum_q  <= csum_q ^ rx_data;
                    end
                    default: ;
                endcase
            end
            if (state_d == ERROR) err_q <= 1'b1;
        end
    end

    assign rx_ready   = rdy_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_reset = (state_q != RUN);
    assign load_done  = (state_q == RUN);
    assign load_error = err_q;
    assign halted     = halt_q;

endmodule
